// File: rtl/rv_pkg.sv
// Shared RISC-V core types and constants.
// Holds the fetch-entry record used by the prefetch stage and its queues.
package rv_pkg;

  localparam int XLEN       = 32;
  localparam int ILEN       = 32;
  localparam int FETCH_STEP = 4;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/rv_fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush, used for both the prefetch
// buffer and the in-flight response-PC queue. DEPTH need not be a power of two.
module rv_fetch_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk_i,
  input  logic         arstn_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t data_i,
  input  logic         pop_i,
  output fetch_entry_t data_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [CW-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (do_push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/rv_prefetch_stage.sv
// Fetch stage with prefetch FIFO, pipelined memory requests and stale-response
// discard after redirects. Define RV_PREFETCH_BYPASS_EN to let responses skip an empty FIFO.
module rv_prefetch_stage
  import rv_pkg::*;
#(
  parameter int              FIFO_DEPTH      = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = 32'h0000_0000
) (
  input  logic            clk_i,
  input  logic            arstn_i,
  input  logic            cu_kill_f_i,
  input  logic            cu_stall_f_i,
  input  logic            cu_force_f_i,
  input  logic [XLEN-1:0] cu_force_pc_i,
  output logic            f_stall_req_o,
  output logic            instr_req_o,
  output logic [XLEN-1:0] instr_addr_o,
  input  logic            instr_gnt_i,
  input  logic            instr_rvalid_i,
  input  logic [XLEN-1:0] instr_rdata_i,
  output logic [ILEN-1:0] f_instr_o,
  output logic [XLEN-1:0] f_current_pc_o,
  output logic [XLEN-1:0] f_next_pc_o,
  output logic            f_valid_o
);

  localparam int OCW = $clog2(MAX_OUTSTANDING + 1);
  localparam int FCW = $clog2(FIFO_DEPTH + 1);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [OCW-1:0]  outstanding_q, outstanding_d;
  logic [OCW-1:0]  discard_q, discard_d;
  logic            f_valid_q, f_valid_d;
  fetch_entry_t    out_q;
  logic [XLEN-1:0] out_next_pc_q;

  logic            xfer, rsp_ok, rsp_drop, rsp_accept, bypass;
  logic            fifo_push, fifo_pop;
  fetch_entry_t    fifo_wdata, fifo_rdata, pcq_wdata, pcq_rdata, load_entry;
  logic            fifo_full, fifo_empty, pcq_full, pcq_empty;
  logic [FCW-1:0]  fifo_count;
  logic [OCW-1:0]  pcq_count;
  logic            unused_ok;

  assign f_stall_req_o = 1'b0;
  assign instr_addr_o  = fetch_pc_q;

  // Only issue when a FIFO slot is reserved for every granted request.
  assign instr_req_o = arstn_i && !cu_force_f_i
                    && (int'(outstanding_q) < MAX_OUTSTANDING)
                    && (int'(outstanding_q) + int'(fifo_count) < FIFO_DEPTH);

  assign xfer       = instr_req_o && instr_gnt_i;
  assign rsp_ok     = instr_rvalid_i && (outstanding_q != '0);
  assign rsp_drop   = rsp_ok && (discard_q != '0);
  assign rsp_accept = rsp_ok && (discard_q == '0) && !cu_force_f_i;
  assign fifo_pop   = !cu_kill_f_i && !cu_stall_f_i && !fifo_empty;

`ifdef RV_PREFETCH_BYPASS_EN
  assign bypass = rsp_accept && fifo_empty && !cu_stall_f_i && !cu_kill_f_i;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_push  = rsp_accept && !bypass;
  assign pcq_wdata  = '{instr: '0, pc: fetch_pc_q};
  assign fifo_wdata = '{instr: ILEN'(instr_rdata_i), pc: pcq_rdata.pc};
  assign load_entry = fifo_pop ? fifo_rdata : fifo_wdata;

  rv_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_prefetch_fifo (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .flush_i (cu_force_f_i),
    .push_i  (fifo_push),
    .data_i  (fifo_wdata),
    .pop_i   (fifo_pop),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  rv_fetch_fifo #(.DEPTH(MAX_OUTSTANDING)) u_rsp_pc_queue (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .flush_i (cu_force_f_i),
    .push_i  (xfer),
    .data_i  (pcq_wdata),
    .pop_i   (rsp_accept),
    .data_o  (pcq_rdata),
    .full_o  (pcq_full),
    .empty_o (pcq_empty),
    .count_o (pcq_count)
  );

  assign unused_ok = ^{fifo_full, pcq_full, pcq_empty, pcq_count, pcq_rdata.instr};

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q + OCW'(xfer) - OCW'(rsp_ok);
    discard_d     = discard_q;
    if (xfer)     fetch_pc_d = fetch_pc_q + XLEN'(FETCH_STEP);
    if (rsp_drop) discard_d  = discard_q - OCW'(1);
    // On redirect every response still in flight belongs to the old stream.
    if (cu_force_f_i) begin
      fetch_pc_d = {cu_force_pc_i[XLEN-1:2], 2'b00};
      discard_d  = outstanding_q - OCW'(rsp_ok);
    end
  end

  always_comb begin
    f_valid_d = f_valid_q;
    if (cu_kill_f_i)       f_valid_d = 1'b0;
    else if (!cu_stall_f_i) f_valid_d = fifo_pop || bypass;
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      f_valid_q     <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      f_valid_q     <= f_valid_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fifo_pop || bypass) begin
      out_q         <= load_entry;
      out_next_pc_q <= load_entry.pc + XLEN'(FETCH_STEP);
    end
  end

  assign f_valid_o      = f_valid_q;
  assign f_instr_o      = out_q.instr;
  assign f_current_pc_o = out_q.pc;
  assign f_next_pc_o    = out_next_pc_q;

`ifndef SYNTHESIS
  rvalid_needs_request: assert property (
    @(posedge clk_i) disable iff (!arstn_i) instr_rvalid_i |-> (outstanding_q != '0));
`endif

endmodule

// File: tb/tb_rv_prefetch_stage.sv
// Directed scoreboard bench for rv_prefetch_stage with an in-order memory model
// of configurable latency; honours RV_PREFETCH_BYPASS_EN for the latency check.
module tb_rv_prefetch_stage;
  import rv_pkg::*;

  localparam int FD = 4;
  localparam int MO = 2;
`ifdef RV_PREFETCH_BYPASS_EN
  localparam int FIRST_VALID_EDGE = 2;
`else
  localparam int FIRST_VALID_EDGE = 3;
`endif

  logic            clk_i = 1'b0;
  logic            arstn_i;
  logic            cu_kill_f_i, cu_stall_f_i, cu_force_f_i;
  logic [XLEN-1:0] cu_force_pc_i;
  logic            f_stall_req_o, instr_req_o, instr_gnt_i, instr_rvalid_i, f_valid_o;
  logic [XLEN-1:0] instr_addr_o, instr_rdata_i, f_current_pc_o, f_next_pc_o;
  logic [ILEN-1:0] f_instr_o;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } memRsp_t;

  int          total = 0;
  int          bad = 0;
  logic [31:0] expQ[$];
  memRsp_t     memQ[$];
  int          memLat = 1;
  int          edgeCount = 0;
  int          grantCount = 0;
  int          consumedCount = 0;
  int          firstValidEdge = -1;
  logic [31:0] modelPc = 32'h0;
  logic [31:0] firstConsumedPc = 32'hDEAD_DEAD;
  logic        sawWrap = 1'b0;

  always #5 clk_i = ~clk_i;

  rv_prefetch_stage #(
    .FIFO_DEPTH(FD),
    .MAX_OUTSTANDING(MO),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk_i          (clk_i),
    .arstn_i        (arstn_i),
    .cu_kill_f_i    (cu_kill_f_i),
    .cu_stall_f_i   (cu_stall_f_i),
    .cu_force_f_i   (cu_force_f_i),
    .cu_force_pc_i  (cu_force_pc_i),
    .f_stall_req_o  (f_stall_req_o),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .f_instr_o      (f_instr_o),
    .f_current_pc_o (f_current_pc_o),
    .f_next_pc_o    (f_next_pc_o),
    .f_valid_o      (f_valid_o)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic kill, input logic stall, input logic force_en,
                               input logic [31:0] forcePc, input logic gnt);
    cu_kill_f_i   = kill;
    cu_stall_f_i  = stall;
    cu_force_f_i  = force_en;
    cu_force_pc_i = forcePc;
    instr_gnt_i   = gnt;
  endtask

  // One clock: sample at the falling edge, then drive memory responses just after the rising edge.
  task automatic tick();
    logic    xfer;
    logic [31:0] pc;
    memRsp_t rsp;
    @(negedge clk_i);
    if (f_valid_o && firstValidEdge < 0) firstValidEdge = edgeCount;
    if (f_valid_o && !cu_stall_f_i && !cu_kill_f_i) begin
      if (expQ.size() == 0) begin
        checkOutput("spurious_valid", {31'b0, f_valid_o}, 32'h0);
      end else begin
        pc = expQ.pop_front();
        checkOutput("out_pc", f_current_pc_o, pc);
        checkOutput("out_instr", f_instr_o, pc | 32'h13);
        checkOutput("out_next_pc", f_next_pc_o, pc + 32'h4);
        if (consumedCount == 0) firstConsumedPc = f_current_pc_o;
        consumedCount++;
        if (pc == 32'hFFFF_FFFC) sawWrap = 1'b1;
      end
    end
    xfer = instr_req_o && instr_gnt_i;
    if (cu_force_f_i) checkOutput("req_in_force", {31'b0, instr_req_o}, 32'h0);
    if (xfer) begin
      checkOutput("fetch_addr", instr_addr_o, modelPc);
      expQ.push_back(modelPc);
      memQ.push_back('{instr_addr_o, edgeCount + memLat});
      modelPc = modelPc + 32'h4;
      grantCount++;
    end
    if (cu_force_f_i) begin
      expQ.delete();
      modelPc = cu_force_pc_i;
    end
    @(posedge clk_i);
    #1;
    edgeCount++;
    if (memQ.size() > 0 && memQ[0].due <= edgeCount) begin
      rsp = memQ.pop_front();
      instr_rvalid_i = 1'b1;
      instr_rdata_i  = rsp.addr | 32'h13;
    end else begin
      instr_rvalid_i = 1'b0;
      instr_rdata_i  = 32'h0;
    end
  endtask

  task automatic applyReset(input logic stall, input logic gnt, input int lat);
    @(posedge clk_i);
    #1;
    arstn_i        = 1'b0;
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = 32'h0;
    applyStimulus(1'b0, stall, 1'b0, 32'h0, gnt);
    memQ.delete();
    expQ.delete();
    memLat        = lat;
    modelPc       = 32'h0;
    grantCount    = 0;
    consumedCount = 0;
    @(negedge clk_i);
    checkOutput("rst_valid", {31'b0, f_valid_o}, 32'h0);
    checkOutput("rst_req", {31'b0, instr_req_o}, 32'h0);
    checkOutput("rst_stall_req", {31'b0, f_stall_req_o}, 32'h0);
    @(posedge clk_i);
    #1;
    arstn_i        = 1'b1;
    edgeCount      = 0;
    firstValidEdge = -1;
  endtask

  initial begin
    arstn_i = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = 32'h0;

    $display("[TB] streaming with 1-cycle memory");
    applyReset(1'b0, 1'b1, 1);
    repeat (8) tick();
    checkOutput("first_valid_edge", firstValidEdge, FIRST_VALID_EDGE);
    checkOutput("stream_consumed", {31'b0, consumedCount >= 4}, 32'h1);

    $display("[TB] grant withheld");
    applyReset(1'b0, 1'b0, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("nogrant_req", {31'b0, instr_req_o}, 32'h1);
      checkOutput("nogrant_addr", instr_addr_o, 32'h0);
      checkOutput("nogrant_valid", {31'b0, f_valid_o}, 32'h0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    repeat (8) tick();
    checkOutput("grant_resume", {31'b0, consumedCount >= 3}, 32'h1);

    $display("[TB] stall fills prefetch buffer");
    applyReset(1'b1, 1'b1, 1);
    repeat (10) tick();
    checkOutput("stall_grants", grantCount, 32'd4);
    checkOutput("stall_req_off", {31'b0, instr_req_o}, 32'h0);
    checkOutput("stall_valid", {31'b0, f_valid_o}, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    repeat (6) tick();
    checkOutput("stall_drained", {31'b0, consumedCount >= 4}, 32'h1);

    $display("[TB] redirect with two requests in flight");
    applyReset(1'b0, 1'b1, 3);
    repeat (2) tick();
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0100, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    consumedCount   = 0;
    firstConsumedPc = 32'hDEAD_DEAD;
    repeat (20) tick();
    checkOutput("redirect_first_pc", firstConsumedPc, 32'h0000_0100);

    $display("[TB] redirect colliding with a response");
    applyReset(1'b0, 1'b1, 1);
    repeat (6) tick();
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0200, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    consumedCount   = 0;
    firstConsumedPc = 32'hDEAD_DEAD;
    repeat (10) tick();
    checkOutput("collide_first_pc", firstConsumedPc, 32'h0000_0200);

    $display("[TB] address wrap");
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    consumedCount   = 0;
    firstConsumedPc = 32'hDEAD_DEAD;
    sawWrap         = 1'b0;
    repeat (12) tick();
    checkOutput("wrap_first_pc", firstConsumedPc, 32'hFFFF_FFF8);
    checkOutput("wrap_seen", {31'b0, sawWrap}, 32'h1);

    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 50 && expQ.size() > 0; i++) tick();
    checkOutput("drain_empty", expQ.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
